// File: rtl/tank_dir_if.sv
// Button/direction bundle between board key logic and the tank direction controller.
// master drives raw buttons; slave (the controller) drives the per-player results.
interface tank_dir_if #(
  parameter int NUM_PLAYERS = 2
);
  logic [4*NUM_PLAYERS-1:0] btn_i;
  logic [3*NUM_PLAYERS-1:0] direction;
  logic [3*NUM_PLAYERS-1:0] facing;
  logic [NUM_PLAYERS-1:0]   dir_change;
  logic [NUM_PLAYERS-1:0]   step;

  modport master (output btn_i, input direction, facing, dir_change, step);
  modport slave  (input btn_i, output direction, facing, dir_change, step);
endinterface

// File: rtl/tank_dir_ctrl.sv
// Per-player button sync/debounce, multi-press resolution and registered direction/facing codes.
// Optional movement strobe divider is built only when TANK_DIR_STEP_EN is defined.
module tank_dir_ctrl #(
  parameter int         NUM_PLAYERS     = 2,
  parameter int         DEBOUNCE_CYCLES = 50000,
  parameter int         PRIORITY_MODE   = 0,
  parameter logic [2:0] FACING_RST      = 3'b100,
  parameter int         STEP_DIV        = 1000000
) (
  input logic       clk,
  input logic       reset,
  tank_dir_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Button bit order is {up,down,left,right}; the returned select is the low two code bits.
  function automatic logic [1:0] pick_sel(input logic [3:0] v);
    if (v[3])      pick_sel = 2'd0;
    else if (v[2]) pick_sel = 2'd1;
    else if (v[1]) pick_sel = 2'd2;
    else           pick_sel = 2'd3;
  endfunction

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [3:0]         sync1_q, sync2_q;
    logic [3:0]         deb_q, deb_d, rise;
    logic [3:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         newest_q, newest_d;
    logic               nvld_q, nvld_d;
    logic [2:0]         dir_q, dir_d;
    logic [2:0]         facing_q, facing_d;
    logic               chg_q, chg_d;

    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      for (int b = 0; b < 4; b++) begin
        if (sync2_q[b] != deb_q[b]) begin
          if (cnt_q[b] == CNT_LAST) deb_d[b] = sync2_q[b];
          else                      cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
    end

    // Newest tracker is updated alongside deb so newest_q always describes deb_q.
    always_comb begin
      rise     = deb_d & ~deb_q;
      newest_d = newest_q;
      nvld_d   = nvld_q;
      if (rise != 4'b0000) begin
        newest_d = pick_sel(rise);
        nvld_d   = 1'b1;
      end else if (nvld_q && !deb_d[2'd3 - newest_q]) begin
        nvld_d = 1'b0;
      end
    end

    always_comb begin
      dir_d = 3'b000;
      if (deb_q == 4'b0000) begin
        dir_d = 3'b000;
      end else if ($onehot(deb_q)) begin
        dir_d = {1'b1, pick_sel(deb_q)};
      end else if (PRIORITY_MODE == 1) begin
        if (nvld_q && deb_q[2'd3 - newest_q]) dir_d = {1'b1, newest_q};
        else                                   dir_d = {1'b1, pick_sel(deb_q)};
      end
      facing_d = (dir_d != 3'b000) ? dir_d : facing_q;
      chg_d    = (dir_d != dir_q);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q  <= '0;
        sync2_q  <= '0;
        deb_q    <= '0;
        cnt_q    <= '0;
        newest_q <= '0;
        nvld_q   <= 1'b0;
        dir_q    <= 3'b000;
        facing_q <= FACING_RST;
        chg_q    <= 1'b0;
      end else begin
        sync1_q  <= bus.btn_i[4*p +: 4];
        sync2_q  <= sync1_q;
        deb_q    <= deb_d;
        cnt_q    <= cnt_d;
        newest_q <= newest_d;
        nvld_q   <= nvld_d;
        dir_q    <= dir_d;
        facing_q <= facing_d;
        chg_q    <= chg_d;
      end
    end

    assign bus.direction[3*p +: 3] = dir_q;
    assign bus.facing[3*p +: 3]    = facing_q;
    assign bus.dir_change[p]       = chg_q;

`ifdef TANK_DIR_STEP_EN
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    logic [SW-1:0] div_q, div_d;
    logic          step_q, step_d;

    // Clearing on the edge that loads a new direction makes the first strobe land STEP_DIV cycles later.
    always_comb begin
      div_d  = '0;
      step_d = 1'b0;
      if (dir_d != 3'b000 && dir_d == dir_q) begin
        if (div_q == SW'(STEP_DIV - 1)) step_d = 1'b1;
        else                            div_d  = div_q + 1'b1;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        div_q  <= '0;
        step_q <= 1'b0;
      end else begin
        div_q  <= div_d;
        step_q <= step_d;
      end
    end

    assign bus.step[p] = step_q;
`else
    assign bus.step[p] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_tank_dir_ctrl.sv
// Directed bench for tank_dir_ctrl: one mode-0 and one mode-1 instance share the same button stimulus.
module tb_tank_dir_ctrl;
  localparam int N = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] btn = '0;
  int         total = 0;
  int         bad = 0;

  tank_dir_if #(.NUM_PLAYERS(N)) bus0 ();
  tank_dir_if #(.NUM_PLAYERS(N)) bus1 ();

  tank_dir_ctrl #(.NUM_PLAYERS(N), .DEBOUNCE_CYCLES(4), .PRIORITY_MODE(0),
                  .FACING_RST(3'b100), .STEP_DIV(8)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  tank_dir_ctrl #(.NUM_PLAYERS(N), .DEBOUNCE_CYCLES(4), .PRIORITY_MODE(1),
                  .FACING_RST(3'b100), .STEP_DIV(8)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // clock / reset
  always #5 clk = ~clk;

  assign bus0.btn_i = btn;
  assign bus1.btn_i = btn;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [1:0] seen;

  initial begin
    // reset state
    #12;
    chk("rst_dir", 32'(bus0.direction), 32'h0);
    chk("rst_facing", 32'(bus0.facing), 32'(6'b100100));
    chk("rst_chg", 32'(bus0.dir_change), 32'h0);
    chk("rst_step", 32'(bus0.step), 32'h0);
    @(negedge clk) reset = 1'b0;
    tick(3);
    chk("rel_chg", 32'(bus0.dir_change), 32'h0);

    // p0 up: direction appears on the 7th edge
    btn = 8'h08;
    tick(6);
    chk("up_e6", 32'(bus0.direction), 32'h0);
    tick(1);
    chk("up_e7", 32'(bus0.direction), 32'(6'b000100));
    chk("up_chg", 32'(bus0.dir_change), 32'h1);
    chk("up_facing", 32'(bus0.facing), 32'(6'b100100));
    chk("up_m1", 32'(bus1.direction), 32'(6'b000100));
    tick(1);
    chk("up_chg_end", 32'(bus0.dir_change), 32'h0);
    btn = 8'h00;
    tick(7);
    chk("upoff_dir", 32'(bus0.direction), 32'h0);
    chk("upoff_chg", 32'(bus0.dir_change), 32'h1);
    chk("upoff_facing", 32'(bus0.facing), 32'(6'b100100));
    tick(2);

    // p1 left glitch of 3 cycles never reaches the output
    seen = '0;
    btn = 8'h20;
    tick(1); seen |= bus0.dir_change;
    tick(1); seen |= bus0.dir_change;
    tick(1); seen |= bus0.dir_change;
    btn = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen |= bus0.dir_change;
    end
    chk("glitch_dir", 32'(bus0.direction), 32'h0);
    chk("glitch_chg", 32'(seen), 32'h0);

    // p1 left pulse of 4 cycles
    btn = 8'h20;
    tick(4);
    btn = 8'h00;
    tick(3);
    chk("pulse_dir", 32'(bus0.direction), 32'(6'b110000));
    chk("pulse_chg", 32'(bus0.dir_change), 32'h2);
    tick(3);
    chk("pulse_hold", 32'(bus0.direction), 32'(6'b110000));
    tick(1);
    chk("pulse_off", 32'(bus0.direction), 32'h0);
    chk("pulse_facing", 32'(bus0.facing), 32'(6'b110100));
    tick(2);

    // p0 up then up+right, then release right
    btn = 8'h08;
    tick(7);
    btn = 8'h09;
    tick(7);
    chk("multi_m0", 32'(bus0.direction), 32'h0);
    chk("multi_m1", 32'(bus1.direction), 32'(6'b000111));
    chk("multi_m1_facing", 32'(bus1.facing), 32'(6'b110111));
    btn = 8'h08;
    tick(7);
    chk("relr_m0", 32'(bus0.direction), 32'(6'b000100));
    chk("relr_m1", 32'(bus1.direction), 32'(6'b000100));
    btn = 8'h00;
    tick(8);

    // newest released: fall back to fixed priority among held buttons
    btn = 8'h04;
    tick(7);
    chk("fb_down", 32'(bus1.direction), 32'(6'b000101));
    btn = 8'h06;
    tick(7);
    chk("fb_left_m1", 32'(bus1.direction), 32'(6'b000110));
    chk("fb_left_m0", 32'(bus0.direction), 32'h0);
    btn = 8'h0E;
    tick(7);
    chk("fb_up_m1", 32'(bus1.direction), 32'(6'b000100));
    btn = 8'h06;
    tick(7);
    chk("fb_prio_m1", 32'(bus1.direction), 32'(6'b000101));
    btn = 8'h00;
    tick(8);

    // same-cycle rises and independent players
    btn = 8'h06;
    tick(7);
    chk("same_m1", 32'(bus1.direction), 32'(6'b000101));
    chk("same_m0", 32'(bus0.direction), 32'h0);
    btn = 8'h00;
    tick(8);
    btn = 8'h81;
    tick(7);
    chk("both_m0", 32'(bus0.direction), 32'(6'b100111));
    chk("both_m1", 32'(bus1.direction), 32'(6'b100111));

    // asynchronous reset while moving, then re-debounce from scratch
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_dir", 32'(bus0.direction), 32'h0);
    chk("mid_rst_facing", 32'(bus0.facing), 32'(6'b100100));
    chk("mid_rst_chg", 32'(bus0.dir_change), 32'h0);
    @(negedge clk) reset = 1'b0;
    tick(6);
    chk("rerel_e6", 32'(bus0.direction), 32'h0);
    tick(1);
    chk("rerel_e7", 32'(bus0.direction), 32'(6'b100111));
    btn = 8'h00;
    tick(8);

    // step strobe
`ifdef TANK_DIR_STEP_EN
    btn = 8'h01;
    tick(7);
    chk("step_start", 32'(bus0.step), 32'h0);
    tick(7);
    chk("step_e7", 32'(bus0.step), 32'h0);
    tick(1);
    chk("step_first", 32'(bus0.step), 32'h1);
    tick(1);
    chk("step_pulse_end", 32'(bus0.step), 32'h0);
    tick(7);
    chk("step_second", 32'(bus0.step), 32'h1);
    btn = 8'h08;
    tick(7);
    chk("step_turn_dir", 32'(bus0.direction), 32'(6'b000100));
    tick(7);
    chk("step_turn_e7", 32'(bus0.step), 32'h0);
    tick(1);
    chk("step_turn_first", 32'(bus0.step), 32'h1);
`else
    seen = '0;
    btn = 8'h01;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      seen |= bus0.step;
    end
    chk("step_moving_dir", 32'(bus0.direction), 32'(6'b000111));
    chk("step_off", 32'(seen), 32'h0);
`endif
    btn = 8'h00;
    tick(2);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
